// File: rtl/md_unit.sv
// Purpose : multi-cycle MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Latency : MD ops finish MULT_CYCLES/DIV_CYCLES edges after acceptance; MTHI/MTLO take effect at the accepting edge.
// Backpressure: busy=1 while an op is in flight; any start seen during that time is dropped.
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low
//   start - EX holds a valid MD instruction this cycle
//   op    - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   a, b  - rs / rt operands
//   busy  - operation in flight
//   hi,lo - HI/LO registers
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    op_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;

    // Result datapath works on the latched operands only, so it is stable
    // for the whole run and consumed at the final edge.
    logic          is_signed;
    logic          neg_a;
    logic          neg_b;
    logic [31:0]   mag_a;
    logic [31:0]   mag_b;
    logic [31:0]   dvsr;
    logic [31:0]   q_mag;
    logic [31:0]   r_mag;
    logic [63:0]   prod_mag;
    logic [63:0]   prod;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;
    logic          res_wr;

    always_comb begin
        is_signed = ~op_q[0];
        neg_a     = is_signed & a_q[31];
        neg_b     = is_signed & b_q[31];
        mag_a     = neg_a ? (32'd0 - a_q) : a_q;
        mag_b     = neg_b ? (32'd0 - b_q) : b_q;

        // Sign-magnitude multiply: magnitude product then negate if signs differ.
        prod_mag  = {32'd0, mag_a} * {32'd0, mag_b};
        prod      = (neg_a ^ neg_b) ? (64'd0 - prod_mag) : prod_mag;

        // Divide-by-zero is steered to a harmless divisor; its result is
        // never written. 0x80000000 / -1 falls out naturally: magnitude
        // 0x80000000 negated wraps back to 0x80000000, remainder 0.
        dvsr      = (b_q == 32'd0) ? 32'd1 : mag_b;
        q_mag     = mag_a / dvsr;
        r_mag     = mag_a % dvsr;

        if (op_q[1] == 1'b0) begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
            res_wr = 1'b1;
        end else begin
            res_lo = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
            res_hi = neg_a ? (32'd0 - r_mag) : r_mag;
            res_wr = (b_q != 32'd0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            op_q  <= 3'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (op[2] == 1'b0) begin
                            op_q  <= op;
                            a_q   <= a;
                            b_q   <= b;
                            cnt   <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end else if (op == 3'd4) begin
                            hi <= a;
                        end else if (op == 3'd5) begin
                            lo <= a;
                        end
                    end
                end
                S_RUN: begin
                    // Counter reaches 0 at this edge: commit and release.
                    if (cnt <= CW'(1)) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        if (res_wr) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

    localparam int NM = 5;
    localparam int ND = 10;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op    = 3'd0;
    logic [31:0] a     = 32'd0;
    logic [31:0] b     = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    md_unit #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int busy_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // An accepted MD op is just a pending (done_cycle, result) record;
    // busy means "a record is pending".
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    bit          m_pend = 1'b0;
    int          cyc = 0;
    int          m_done = 0;
    logic [31:0] p_hi, p_lo;
    bit          p_wr;

    function automatic void ref_calc(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                     output bit wr, output logic [31:0] h, output logic [31:0] l);
        longint          sp;
        longint unsigned up;
        int              sx, sy;
        wr = 1'b1;
        h  = 32'd0;
        l  = 32'd0;
        sx = int'(x);
        sy = int'(y);
        case (o)
            3'd0: begin
                sp = longint'(sx) * longint'(sy);
                h = sp[63:32];
                l = sp[31:0];
            end
            3'd1: begin
                up = longint'({32'd0, x}) * longint'({32'd0, y});
                h = up[63:32];
                l = up[31:0];
            end
            3'd2: begin
                if (y == 32'd0) wr = 1'b0;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    l = 32'h8000_0000;
                    h = 32'd0;
                end else begin
                    l = sx / sy;
                    h = sx % sy;
                end
            end
            default: begin
                if (y == 32'd0) wr = 1'b0;
                else begin
                    l = x / y;
                    h = x % y;
                end
            end
        endcase
    endfunction

    always @(posedge clk) begin
        bit was_busy;
        if (reset) begin
            cyc++;
            was_busy = m_pend;
            if (m_pend && cyc == m_done) begin
                if (p_wr) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end
                m_pend = 1'b0;
            end
            if (!was_busy && start) begin
                if (op <= 3'd3) begin
                    ref_calc(op, a, b, p_wr, p_hi, p_lo);
                    m_pend = 1'b1;
                    m_done = cyc + ((op >= 3'd2) ? ND : NM);
                end else if (op == 3'd4) m_hi = a;
                else if (op == 3'd5) m_lo = a;
            end
        end
    end

    always @(negedge reset) begin
        m_pend = 1'b0;
        m_hi   = 32'd0;
        m_lo   = 32'd0;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (reset) begin
            chk("cyc_busy", {31'd0, busy}, {31'd0, m_pend});
            chk("cyc_hi", hi, m_hi);
            chk("cyc_lo", lo, m_lo);
            if (busy === 1'b1) busy_cnt++;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(posedge clk);
        #2;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy !== 1'b0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("wait_idle_timeout", {31'd0, busy}, 32'd0);
        #1;
    endtask

    task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int exp_cyc, input logic [31:0] eh, input logic [31:0] el);
        int c0;
        c0 = busy_cnt;
        issue(o, x, y);
        wait_idle();
        chk({nm, "_cycles"}, busy_cnt - c0, exp_cyc);
        chk({nm, "_hi"}, hi, eh);
        chk({nm, "_lo"}, lo, el);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        #5 reset = 1'b1;

        run_op("mult",  3'd0, 32'hFFFF_FFFE, 32'd3, NM, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, NM, 32'h0000_0002, 32'hFFFF_FFFA);
        run_op("div",   3'd2, 32'hFFFF_FFF9, 32'd2, ND, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu",  3'd3, 32'hFFFF_FFF9, 32'd2, ND, 32'h0000_0001, 32'h7FFF_FFFC);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, ND, 32'd0, 32'h8000_0000);

        issue(3'd4, 32'h1234, 32'd0);
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        issue(3'd5, 32'h5678, 32'd0);
        chk("mtlo_lo", lo, 32'h5678);
        run_op("divu_zero", 3'd3, 32'd99, 32'd0, ND, 32'h1234, 32'h5678);
        run_op("div_zero",  3'd2, 32'd99, 32'd0, ND, 32'h1234, 32'h5678);

        issue(3'd4, 32'hDEAD_BEEF, 32'd0);
        chk("mthi2_hi", hi, 32'hDEAD_BEEF);
        chk("mthi2_busy", {31'd0, busy}, 32'd0);

        // MULT with a stray MTLO during the run, then back-to-back MULTU.
        c0 = busy_cnt;
        issue(3'd0, 32'd6, 32'd7);
        issue(3'd5, 32'hAAAA_AAAA, 32'd0);
        wait_idle();
        chk("mult67_lo", lo, 32'd42);
        chk("mult67_hi", hi, 32'd0);
        issue(3'd1, 32'h0001_0000, 32'h0001_0000);
        wait_idle();
        chk("multu_big_hi", hi, 32'd1);
        chk("multu_big_lo", lo, 32'd0);
        chk("b2b_busy_total", busy_cnt - c0, 2 * NM);

        // Reset mid-run: DIVU 100/7, reset pulled low for 3 ns during the run.
        issue(3'd3, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        #2 reset = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("rst_after_busy", {31'd0, busy}, 32'd0);
        chk("rst_after_hi", hi, 32'd0);
        chk("rst_after_lo", lo, 32'd0);

        // Randomized traffic, occasionally with a stray start during a run.
        for (int i = 0; i < 250; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick());
            if (busy === 1'b1 && $urandom_range(0, 3) == 0)
                issue(3'($urandom_range(0, 7)), pick(), pick());
            wait_idle();
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
